// File: rtl/serial_subtractor_16bits.sv
// serial_subtractor_16bits: bit-serial a - b - b_in, LSB first, with borrow, overflow and zero flags
module serial_subtractor_16bits #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, d_sh, d_next;
  logic [CNT_W-1:0] cnt;
  logic             brw, a_msb, b_msb, d, brw_next;
  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ brw;
    brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
    d_next   = {d, d_sh[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      b_out <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          a_sh  <= a;
          b_sh  <= b;
          brw   <= b_in;
          cnt   <= '0;
          a_msb <= a[WIDTH-1];
          b_msb <= b[WIDTH-1];
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_next;
          brw  <= brw_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            diff  <= d_next;
            b_out <= brw_next;
            ovf   <= (a_msb != b_msb) && (d != a_msb);
            zero  <= d_next == '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor_16bits.sv
// tb_serial_subtractor_16bits: directed and random checks of the serial subtractor
module tb_serial_subtractor_16bits;
  logic        clk = 0, rst = 1, start = 0, b_in = 0;
  logic [15:0] a = 0, b = 0;
  logic        busy, done, b_out, ovf, zero;
  logic [15:0] diff;
  int          checks = 0, errors = 0, cyc = 0;

  serial_subtractor_16bits dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .b_out(b_out), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                    input logic [15:0] ed, input logic eb, input logic eo, input logic ez,
                    input logic abuse);
    int n = 0, bcnt = 0;
    @(negedge clk);
    a = ta; b = tb; b_in = tbin; start = 1;
    @(negedge clk);
    start = 0;
    n = 1;
    bcnt += int'(busy);
    while (!done && n < 40) begin
      if (abuse && n == 5) begin
        a = ~ta; b = ta; b_in = ~tbin; start = 1;
      end else start = 0;
      @(negedge clk);
      n++;
      bcnt += int'(busy);
    end
    start = 0;
    check("latency", n, 17);
    check("busy_hi", bcnt, n);
    check("diff", diff, ed);
    check("flags", {b_out, ovf, zero}, {eb, eo, ez});
    @(negedge clk);
    check("end", {busy, done}, 2'b00);
  endtask

  initial begin
    logic [15:0] ra, rb, ed;
    logic        rbin, eb;
    int          k, t1, t2, dc;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (20) begin
      @(negedge clk);
      check("idle", {busy, done, b_out, ovf, zero, diff}, 0);
    end
    op(16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0, 0);
    op(16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0, 0);
    op(16'h0005, 16'h0005, 1, 16'hFFFF, 1, 0, 0, 0);
    op(16'h8000, 16'h0001, 0, 16'h7FFF, 0, 1, 0, 0);
    op(16'h7FFF, 16'hFFFF, 0, 16'h8000, 1, 1, 0, 0);
    op(16'hABCD, 16'hABCD, 0, 16'h0000, 0, 0, 1, 0);
    op(16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 1, 0);
    op(16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0, 1);
    op(16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0, 0);
    // start held high: operations relaunch back to back
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; b_in = 0; start = 1;
    k = 0;
    while (!done && k < 60) begin @(negedge clk); k++; end
    t1 = cyc;
    @(negedge clk);
    k = 0;
    while (!done && k < 60) begin @(negedge clk); k++; end
    t2 = cyc;
    check("held_spacing", t2 - t1, 18);
    check("held_diff", diff, 16'h1000);
    start = 0;
    repeat (2) @(negedge clk);
    // reset in the middle of RUN
    a = 16'h00FF; b = 16'h0001; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rst_clear", {busy, done, b_out, ovf, zero, diff}, 0);
    dc = 0;
    repeat (25) begin @(negedge clk); dc += int'(done); end
    check("rst_nodone", dc, 0);
    op(16'h00FF, 16'h0001, 0, 16'h00FE, 0, 0, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rbin = 1'($urandom);
      {eb, ed} = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
      op(ra, rb, rbin, ed, eb, (ra[15] != rb[15]) && (ed[15] != ra[15]), ed == 0, 0);
      check("readd", 16'(diff + rb + 16'(rbin)), ra);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
